// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: ID-stage control decoder feeding a registered EX control
// bundle. Detects load-use hazards, applies flush/stall priority, and drains
// the pipe with bubbles before raising a one-cycle syscall pulse.
module decode_ctrl_stage #(
    parameter int ALU_W        = 5,
    parameter int BCU_W        = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [5:0]       op_code,
    input  logic [5:0]       funct_code,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [4:0]       rd,
    input  logic             ex_stall,
    input  logic             flush,
    output logic             id_ready,
    output logic             hazard_stall,
    output logic             ex_valid,
    output logic             ex_load_upper,
    output logic             ex_jal,
    output logic             ex_reg_write,
    output logic             ex_mem_to_reg,
    output logic             ex_mem_write,
    output logic             ex_alu_src,
    output logic             ex_reg_dst,
    output logic             ex_branch,
    output logic [1:0]       ex_jump,
    output logic [ALU_W-1:0] ex_alu_control,
    output logic [BCU_W-1:0] ex_bcu_control,
    output logic [4:0]       ex_dst_reg,
    output logic             illegal_op,
    output logic             syscall
);

    // Opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL function codes
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2A;

    // ALU and branch-compare operation codes; zero means "no operation"
    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(5);

    localparam logic [BCU_W-1:0] BCU_EQ  = BCU_W'(1);
    localparam logic [BCU_W-1:0] BCU_NE  = BCU_W'(2);
    localparam logic [BCU_W-1:0] BCU_LEZ = BCU_W'(3);
    localparam logic [BCU_W-1:0] BCU_GTZ = BCU_W'(4);

    typedef struct packed {
        logic             valid;
        logic             load_upper;
        logic             jal;
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_write;
        logic             alu_src;
        logic             reg_dst;
        logic             branch;
        logic [1:0]       jump;
        logic [ALU_W-1:0] alu;
        logic [BCU_W-1:0] bcu;
        logic [4:0]       dst;
    } ex_t;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SYS} state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    ex_t        r_ex;
    ex_t        w_dec;
    logic       r_illegal;
    logic       w_illegal;
    logic       w_is_sys;
    logic       w_reads_rt;
    logic       w_accept;
    logic       w_flush_run;

    // Decode the ID instruction into an EX control bundle; unknown encodings give all-zero controls
    always_comb begin
        w_dec       = '0;
        w_dec.valid = 1'b1;
        w_illegal   = 1'b0;
        w_is_sys    = 1'b0;
        case (op_code)
            OP_SPECIAL: begin
                case (funct_code)
                    FN_ADD, FN_ADDU: begin w_dec.reg_write = 1'b1; w_dec.reg_dst = 1'b1; w_dec.alu = ALU_ADD; end
                    FN_SUB:          begin w_dec.reg_write = 1'b1; w_dec.reg_dst = 1'b1; w_dec.alu = ALU_SUB; end
                    FN_AND:          begin w_dec.reg_write = 1'b1; w_dec.reg_dst = 1'b1; w_dec.alu = ALU_AND; end
                    FN_OR:           begin w_dec.reg_write = 1'b1; w_dec.reg_dst = 1'b1; w_dec.alu = ALU_OR;  end
                    FN_SLT:          begin w_dec.reg_write = 1'b1; w_dec.reg_dst = 1'b1; w_dec.alu = ALU_SLT; end
                    FN_JR:           w_dec.jump = 2'b10;
                    FN_SYSCALL:      w_is_sys = 1'b1;
                    default:         w_illegal = 1'b1;
                endcase
            end
            OP_LUI:   begin w_dec.load_upper = 1'b1; w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; end
            OP_J:     w_dec.jump = 2'b01;
            OP_JAL:   begin w_dec.jump = 2'b01; w_dec.jal = 1'b1; w_dec.reg_write = 1'b1; end
            OP_ADDI, OP_ADDIU: begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_dec.alu = ALU_ADD; end
            OP_ORI:   begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_dec.alu = ALU_OR; end
            OP_LW:    begin w_dec.reg_write = 1'b1; w_dec.mem_to_reg = 1'b1; w_dec.alu_src = 1'b1; w_dec.alu = ALU_ADD; end
            OP_SW:    begin w_dec.mem_write = 1'b1; w_dec.alu_src = 1'b1; w_dec.alu = ALU_ADD; end
            OP_BEQ:   begin w_dec.branch = 1'b1; w_dec.bcu = BCU_EQ;  end
            OP_BNE:   begin w_dec.branch = 1'b1; w_dec.bcu = BCU_NE;  end
            OP_BLEZ:  begin w_dec.branch = 1'b1; w_dec.bcu = BCU_LEZ; end
            OP_BGTZ:  begin w_dec.branch = 1'b1; w_dec.bcu = BCU_GTZ; end
            default:  w_illegal = 1'b1;
        endcase
        if (w_illegal)          w_dec.dst = 5'd0;
        else if (w_dec.reg_dst) w_dec.dst = rd;
        else if (w_dec.jal)     w_dec.dst = 5'd31;
        else                    w_dec.dst = rt;
    end

    // rt is a source operand only for R-type, stores and the two-register branches
    assign w_reads_rt = (op_code == OP_SPECIAL) | (op_code == OP_SW) |
                        (op_code == OP_BEQ) | (op_code == OP_BNE);

    assign hazard_stall = ex_valid & ex_mem_to_reg & (ex_dst_reg != 5'd0) & id_valid &
                          ((ex_dst_reg == rs) | ((ex_dst_reg == rt) & w_reads_rt));

    assign id_ready    = (r_state == ST_RUN) & ~ex_stall & ~hazard_stall;
    // A flushed ID instruction is dropped, so it has no side effects
    assign w_accept    = id_valid & id_ready & ~flush;
    // Flush only matters while running; a syscall in flight is always the oldest
    assign w_flush_run = flush & (r_state == ST_RUN);

    // State and drain counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: enter drain on an accepted syscall, count down unstalled cycles, pulse once
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_accept & w_is_sys) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = 4'(DRAIN_CYCLES);
                end
            end
            ST_DRAIN: begin
                if (!ex_stall) begin
                    if (r_cnt <= 4'd1) begin
                        w_state_nxt = ST_SYS;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
            end
            ST_SYS:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // EX register: flush bubble, then stall hold, then accepted instruction, else bubble
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept & w_illegal;
            if (w_flush_run)    r_ex <= '0;
            else if (ex_stall)  r_ex <= r_ex;
            else if (w_accept)  r_ex <= w_dec;
            else                r_ex <= '0;
        end
    end

    assign ex_valid       = r_ex.valid;
    assign ex_load_upper  = r_ex.load_upper;
    assign ex_jal         = r_ex.jal;
    assign ex_reg_write   = r_ex.reg_write;
    assign ex_mem_to_reg  = r_ex.mem_to_reg;
    assign ex_mem_write   = r_ex.mem_write;
    assign ex_alu_src     = r_ex.alu_src;
    assign ex_reg_dst     = r_ex.reg_dst;
    assign ex_branch      = r_ex.branch;
    assign ex_jump        = r_ex.jump;
    assign ex_alu_control = r_ex.alu;
    assign ex_bcu_control = r_ex.bcu;
    assign ex_dst_reg     = r_ex.dst;
    assign illegal_op     = r_illegal;
    assign syscall        = (r_state == ST_SYS);

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: scoreboard bench for decode_ctrl_stage. A table of
// supported instructions and a small pipeline/syscall model predict each
// cycle's EX bundle; a monitor compares after every rising edge.
module tb_decode_ctrl_stage;

    localparam int DRAIN = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_valid;
    logic [5:0] op_code, funct_code;
    logic [4:0] rs, rt, rd;
    logic       ex_stall, flush;
    logic       id_ready, hazard_stall, ex_valid;
    logic       ex_load_upper, ex_jal, ex_reg_write, ex_mem_to_reg, ex_mem_write;
    logic       ex_alu_src, ex_reg_dst, ex_branch;
    logic [1:0] ex_jump;
    logic [4:0] ex_alu_control;
    logic [3:0] ex_bcu_control;
    logic [4:0] ex_dst_reg;
    logic       illegal_op, syscall;

    decode_ctrl_stage #(.ALU_W(5), .BCU_W(4), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .op_code(op_code),
        .funct_code(funct_code), .rs(rs), .rt(rt), .rd(rd), .ex_stall(ex_stall),
        .flush(flush), .id_ready(id_ready), .hazard_stall(hazard_stall),
        .ex_valid(ex_valid), .ex_load_upper(ex_load_upper), .ex_jal(ex_jal),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alu_control(ex_alu_control),
        .ex_bcu_control(ex_bcu_control), .ex_dst_reg(ex_dst_reg),
        .illegal_op(illegal_op), .syscall(syscall)
    );

    always #5 clk = ~clk;

    // f bits: load_upper, jal, reg_write, mem_to_reg, mem_write, alu_src, reg_dst, branch
    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       special;
        logic [7:0] f;
        logic [1:0] jump;
        logic [4:0] alu;
        logic [3:0] bcu;
    } ent_t;

    ent_t         tbl[$];
    logic [26:0]  exp_q[$];
    int           tests = 0;
    int           fails = 0;

    // Model state: expected EX bundle {valid,f[7:0],jump,alu,bcu,dst} and syscall progress
    logic [24:0]  m_ex;
    bit           m_drain, m_sys;
    int           m_left;

    task automatic add(input logic [5:0] op, fn, input logic sp, input logic [7:0] f,
                       input logic [1:0] j, input logic [4:0] a, input logic [3:0] b);
        ent_t e;
        e.op = op; e.fn = fn; e.special = sp; e.f = f; e.jump = j; e.alu = a; e.bcu = b;
        tbl.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [26:0] dut_vec();
        return {ex_valid, ex_load_upper, ex_jal, ex_reg_write, ex_mem_to_reg, ex_mem_write,
                ex_alu_src, ex_reg_dst, ex_branch, ex_jump, ex_alu_control, ex_bcu_control,
                ex_dst_reg, illegal_op, syscall};
    endfunction

    function automatic bit reads_rt(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
    endfunction

    function automatic logic [24:0] expect_dec(input logic [5:0] op, fn, input logic [4:0] t, d,
                                               output bit found, output bit is_sys);
        ent_t       e;
        logic [4:0] dst;
        found  = 1'b0;
        is_sys = 1'b0;
        e      = '0;
        foreach (tbl[i])
            if (!found && tbl[i].op == op && (!tbl[i].special || tbl[i].fn == fn)) begin
                found = 1'b1;
                e     = tbl[i];
            end
        if (!found) return {1'b1, 24'b0};
        is_sys = e.special && (e.fn == 6'h0C);
        dst    = e.f[1] ? d : (e.f[6] ? 5'd31 : t);
        return {1'b1, e.f, e.jump, e.alu, e.bcu, dst};
    endfunction

    // One cycle of stimulus: drive, check combinational outputs, predict the next EX state
    task automatic step(input logic v, input logic [5:0] op, fn, input logic [4:0] s, t, d,
                        input logic st, fl);
        bit          run, hz, rdy, acc, found, is_sys, ill;
        logic [24:0] dec;
        @(negedge clk);
        id_valid = v; op_code = op; funct_code = fn; rs = s; rt = t; rd = d;
        ex_stall = st; flush = fl;
        #1;
        run = !m_drain && !m_sys;
        hz  = m_ex[24] && m_ex[20] && (m_ex[4:0] != 5'd0) && v &&
              ((m_ex[4:0] == s) || ((m_ex[4:0] == t) && reads_rt(op)));
        rdy = run && !st && !hz;
        chk("hazard_stall", 32'(hazard_stall), 32'(hz));
        chk("id_ready", 32'(id_ready), 32'(rdy));
        dec = expect_dec(op, fn, t, d, found, is_sys);
        acc = v && rdy && !fl;
        if (run && fl)  m_ex = '0;
        else if (st)    m_ex = m_ex;
        else if (acc)   m_ex = dec;
        else            m_ex = '0;
        ill = acc && !found;
        if (m_sys) m_sys = 1'b0;
        else if (m_drain) begin
            if (!st) begin
                m_left--;
                if (m_left == 0) begin m_drain = 1'b0; m_sys = 1'b1; end
            end
        end else if (acc && is_sys) begin
            m_drain = 1'b1;
            m_left  = DRAIN;
        end
        exp_q.push_back({m_ex, ill, m_sys});
    endtask

    task automatic idle(input logic st, fl);
        step(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, st, fl);
    endtask

    // Accept a syscall, then measure the ready-low window and the pulse position
    task automatic sys_timing(input int sa, input int sb, input int req);
        int lowc, sysk;
        lowc = 0; sysk = 0;
        step(1'b1, 6'h00, 6'h0C, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #2;
            if (syscall && sysk == 0) sysk = k;
            if (id_ready) break;
            lowc++;
            step(1'b1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd3, (k >= sa && k <= sb), (k == sb + 1));
        end
        chk("ready_low_cycles", 32'(lowc), 32'(req));
        chk("syscall_cycle", 32'(sysk), 32'(req));
    endtask

    // Monitor: after each rising edge, compare the DUT outputs with the queued prediction
    always begin
        logic [26:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ex_bundle", 32'(dut_vec()), 32'(e));
        end
    end

    initial begin
        add(6'h00, 6'h20, 1'b1, 8'h22, 2'd0, 5'd1, 4'd0);  // ADD
        add(6'h00, 6'h21, 1'b1, 8'h22, 2'd0, 5'd1, 4'd0);  // ADDU
        add(6'h00, 6'h22, 1'b1, 8'h22, 2'd0, 5'd2, 4'd0);  // SUB
        add(6'h00, 6'h24, 1'b1, 8'h22, 2'd0, 5'd3, 4'd0);  // AND
        add(6'h00, 6'h25, 1'b1, 8'h22, 2'd0, 5'd4, 4'd0);  // OR
        add(6'h00, 6'h2A, 1'b1, 8'h22, 2'd0, 5'd5, 4'd0);  // SLT
        add(6'h00, 6'h08, 1'b1, 8'h00, 2'd2, 5'd0, 4'd0);  // JR
        add(6'h00, 6'h0C, 1'b1, 8'h00, 2'd0, 5'd0, 4'd0);  // SYSCALL
        add(6'h0F, 6'h00, 1'b0, 8'hA4, 2'd0, 5'd0, 4'd0);  // LUI
        add(6'h02, 6'h00, 1'b0, 8'h00, 2'd1, 5'd0, 4'd0);  // J
        add(6'h03, 6'h00, 1'b0, 8'h60, 2'd1, 5'd0, 4'd0);  // JAL
        add(6'h08, 6'h00, 1'b0, 8'h24, 2'd0, 5'd1, 4'd0);  // ADDI
        add(6'h09, 6'h00, 1'b0, 8'h24, 2'd0, 5'd1, 4'd0);  // ADDIU
        add(6'h0D, 6'h00, 1'b0, 8'h24, 2'd0, 5'd4, 4'd0);  // ORI
        add(6'h23, 6'h00, 1'b0, 8'h34, 2'd0, 5'd1, 4'd0);  // LW
        add(6'h2B, 6'h00, 1'b0, 8'h0C, 2'd0, 5'd1, 4'd0);  // SW
        add(6'h04, 6'h00, 1'b0, 8'h01, 2'd0, 5'd0, 4'd1);  // BEQ
        add(6'h05, 6'h00, 1'b0, 8'h01, 2'd0, 5'd0, 4'd2);  // BNE
        add(6'h06, 6'h00, 1'b0, 8'h01, 2'd0, 5'd0, 4'd3);  // BLEZ
        add(6'h07, 6'h00, 1'b0, 8'h01, 2'd0, 5'd0, 4'd4);  // BGTZ

        m_ex = '0; m_drain = 1'b0; m_sys = 1'b0; m_left = 0;
        reset_n = 1'b0; id_valid = 1'b0; op_code = '0; funct_code = '0;
        rs = '0; rt = '0; rd = '0; ex_stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outputs", 32'(dut_vec()), 32'd0);
        chk("reset_hazard", 32'(hazard_stall), 32'd0);
        reset_n = 1'b1;

        // ADDU rs=1 rt=2 rd=3
        step(1'b1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        // Load-use: LW rt=5 then ADDU rs=5 held in ID
        step(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
        step(1'b1, 6'h00, 6'h21, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0);
        step(1'b1, 6'h00, 6'h21, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0);
        // Load-use through rt of a store, with flush on the hazard cycle
        step(1'b1, 6'h23, 6'h00, 5'd1, 5'd7, 5'd0, 1'b0, 1'b0);
        step(1'b1, 6'h2B, 6'h00, 5'd2, 5'd7, 5'd0, 1'b0, 1'b1);
        // Load into $0 never stalls; ex_stall holds an entry
        step(1'b1, 6'h23, 6'h00, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        step(1'b1, 6'h00, 6'h21, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);
        step(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        step(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        // Unsupported opcode and funct
        step(1'b1, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        step(1'b1, 6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        idle(1'b0, 1'b0);

        // Syscall drain: plain, then with two stall cycles and a flush inside drain
        sys_timing(99, 98, DRAIN + 1);
        sys_timing(2, 3, DRAIN + 3);

        // Reset in the middle of a drain aborts it; first accept right after release
        step(1'b1, 6'h00, 6'h0C, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        @(posedge clk); #3;
        reset_n = 1'b0; id_valid = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(dut_vec()), 32'd0);
        m_ex = '0; m_drain = 1'b0; m_sys = 1'b0; m_left = 0;
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #2;
        reset_n = 1'b1;
        step(1'b1, 6'h00, 6'h21, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        repeat (6) idle(1'b0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            int         r;
            logic [5:0] op, fn;
            r = int'($urandom_range(0, 24));
            if (r < 20)       begin op = tbl[r].op; fn = tbl[r].fn; end
            else if (r < 23)  begin op = 6'($urandom); fn = 6'($urandom); end
            else if (r == 23) begin op = 6'h00; fn = 6'($urandom); end
            else              begin op = 6'h3F; fn = 6'h00; end
            step(($urandom_range(0, 9) < 8), op, fn,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) == 0));
        end
        idle(1'b0, 1'b0);
        @(posedge clk); #3;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_stage.md
DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

Interface
REQ-001 Parameters SHALL be: ALU_W, default 5, alu_control width; BCU_W, default 4, bcu_control width; DRAIN_CYCLES, default 3, bubble cycles before syscall, legal range 1..15.
REQ-002 Ports SHALL be, one per line (name direction width meaning):
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- id_valid  in  1  instruction present in ID
- op_code  in  6  opcode
- funct_code  in  6  R-type function
- rs, rt, rd  in  5 each  register fields
- ex_stall  in  1  downstream holds EX register
- flush  in  1  taken branch/jump; kill ID and EX
- id_ready  out  1  ID instruction accepted this cycle
- hazard_stall  out  1  load-use bubble inserted
- ex_valid  out  1  EX register holds a live instruction
- ex_load_upper, ex_jal, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_dst, ex_branch  out  1 each  registered controls
- ex_jump  out  2  00 none, 01 J/JAL, 10 JR
- ex_alu_control  out  ALU_W  ALU op
- ex_bcu_control  out  BCU_W  branch compare op
- ex_dst_reg  out  5  rd if reg_dst, 31 if jal, else rt
- illegal_op  out  1  one-cycle pulse, unsupported instruction accepted
- syscall  out  1  one-cycle pulse after drain

Function
REQ-003 Decode SHALL use the team header encodings for LUI, J, JAL, ADDI, ADDIU, ORI, LW, SW, BEQ, BNE, BLEZ, BGTZ, and SPECIAL with ADD, ADDU, SUB, AND, OR, SLT, JR, SYSCALL; field meanings as the existing single-cycle decoder.
REQ-004 Unsupported op/funct SHALL produce all-zero controls (never X), ex_valid=1, illegal_op pulse on the accept edge.
REQ-005 Accept condition: id_valid & id_ready; on accept the decoded bundle SHALL load into the EX register at the next rising edge (latency 1).
REQ-006 id_ready SHALL equal state==RUN & !ex_stall & !hazard_stall.
REQ-007 hazard_stall SHALL be 1 when ex_valid & ex_mem_to_reg & ex_dst_reg!=0 & id_valid & (ex_dst_reg==rs | (ex_dst_reg==rt & instruction reads rt)); rt is read by R-type, SW, BEQ, BNE.
REQ-008 On hazard_stall without ex_stall, the EX register SHALL load a bubble (ex_valid=0, all controls 0) and ID SHALL be held.
REQ-009 ex_stall SHALL hold the EX register unchanged; it overrides hazard and drain bubbles.
REQ-010 flush (state RUN) SHALL load a bubble into EX and drop the ID instruction; flush overrides ex_stall and hazard.
REQ-011 FSM states SHALL be RUN, DRAIN, SYS. RUN->DRAIN on accepting SYSCALL (SYSCALL enters EX with ex_valid=1, reg_write=0).
REQ-012 DRAIN SHALL hold id_ready=0, insert bubbles, and decrement a counter loaded with DRAIN_CYCLES; counter advances only when ex_stall=0; at count 0 -> SYS.
REQ-013 SYS SHALL assert syscall for exactly one cycle, then return to RUN.
REQ-014 flush SHALL be ignored in DRAIN and SYS (syscall is oldest in flight).
REQ-015 Simultaneous hazard and flush: flush wins, hazard_stall still reported combinationally, no bubble double-count.

Reset
REQ-016 reset_n low SHALL asynchronously force state RUN, drain counter 0, ex_valid 0, every ex_* control 0, ex_dst_reg 0, illegal_op 0, syscall 0.
REQ-017 Reset asserted mid-DRAIN SHALL abort the drain with no syscall pulse; first accept is possible on the first edge after release.

Verification
REQ-018 ADDU rs=1 rt=2 rd=3 accepted -> next cycle ex_valid=1, ex_reg_write=1, ex_reg_dst=1, ex_alu_src=0, ex_dst_reg=3, ex_alu_control=ALU_add.
REQ-019 LW rt=5 then ADDU rs=5 -> hazard_stall=1 one cycle, EX bubble, ADDU enters EX on following edge.
REQ-020 SYSCALL with DRAIN_CYCLES=3, ex_stall low -> id_ready=0 for 4 cycles, syscall pulses 4 cycles after accept, then id_ready=1.
REQ-021 DRAIN with ex_stall high 2 cycles -> syscall pulse delayed by exactly 2 cycles; flush in DRAIN has no effect.
REQ-022 op_code 6'h3F accepted -> illegal_op one-cycle pulse, all ex controls 0, ex_valid=1.
REQ-023 reset_n low during DRAIN -> all outputs 0 immediately; no syscall pulse after release.
